// File: rtl/clic_irq_sched_if.sv
// clic_irq_sched_if
//   Bundles the source-array inputs, the decode request/ack handshake and the
//   gateway pending-clear of the CLIC interrupt scheduler.
//   master : scheduler side (drives irq_o, irq_level_o, clr_o)
//   slave  : environment side (CLIC source array, CSRs and decode)
// Signals
//   pending_i, enable_i, edge_i   per-source pending / enable / edge-triggered flags
//   level_i                       per-source level, source i at [i*LevelWidth +: LevelWidth]
//   mintthresh_i, mil_i, mie_i    threshold CSR, running handler level, global enable
//   irq_o, irq_level_o            one-hot request and its level towards decode
//   irq_ack_i                     decode took the request (single-cycle pulse)
//   clr_o                         one-hot pending-clear pulse towards the gateway
interface clic_irq_sched_if #(
  parameter int NumSrc     = 64,
  parameter int LevelWidth = 8
);
  logic [NumSrc-1:0]            pending_i;
  logic [NumSrc-1:0]            enable_i;
  logic [NumSrc-1:0]            edge_i;
  logic [NumSrc*LevelWidth-1:0] level_i;
  logic [LevelWidth-1:0]        mintthresh_i;
  logic [LevelWidth-1:0]        mil_i;
  logic                         mie_i;
  logic [NumSrc-1:0]            irq_o;
  logic [LevelWidth-1:0]        irq_level_o;
  logic                         irq_ack_i;
  logic [NumSrc-1:0]            clr_o;

  modport master (
    input  pending_i, enable_i, edge_i, level_i, mintthresh_i, mil_i, mie_i, irq_ack_i,
    output irq_o, irq_level_o, clr_o
  );

  modport slave (
    output pending_i, enable_i, edge_i, level_i, mintthresh_i, mil_i, mie_i, irq_ack_i,
    input  irq_o, irq_level_o, clr_o
  );
endinterface

// File: rtl/clic_irq_sched.sv
// clic_irq_sched
//   Interrupt scheduler between the CLIC source array and the decode stage.
//   Arbitrates the highest-level eligible source above max(mintthresh, mil),
//   holds it as a one-hot request until decode acks, then pulses a pending
//   clear for edge-triggered sources. A held request is withdrawn when it is
//   no longer eligible or when a strictly higher level source appears.
// Ports
//   clk_i   clock
//   rst_ni  asynchronous reset, active low
//   bus     clic_irq_sched_if.master (source inputs, request/ack, clear)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no request driven; latch the arbitration winner when one exists
// REQ   | request for the latched winner held stable until ack/withdraw
// CLEAR | one cycle after ack; clear pulse for edge sources, then IDLE
module clic_irq_sched #(
  parameter int NumSrc     = 64,
  parameter int LevelWidth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  clic_irq_sched_if.master bus
);
  localparam int IdWidth = $clog2(NumSrc);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CLEAR = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IdWidth-1:0]      win_id_q;
  logic [LevelWidth-1:0]   win_lvl_q;
  logic                    load_win;

  logic [LevelWidth-1:0]   eff_thr;
  logic [LevelWidth-1:0]   src_lvl [NumSrc];
  logic [NumSrc-1:0]       eligible;
  logic                    cand_valid;
  logic [IdWidth-1:0]      cand_id;
  logic [LevelWidth-1:0]   cand_lvl;
  logic [NumSrc-1:0]       win_onehot;

  assign eff_thr = (bus.mintthresh_i > bus.mil_i) ? bus.mintthresh_i : bus.mil_i;

  always_comb begin
    for (int i = 0; i < NumSrc; i++) begin
      src_lvl[i]  = bus.level_i[i*LevelWidth +: LevelWidth];
      eligible[i] = bus.pending_i[i] & bus.enable_i[i] & bus.mie_i &
                    (src_lvl[i] > eff_thr);
    end
  end

  // Ascending scan with a strict compare keeps the lowest index on level ties.
  always_comb begin
    cand_valid = 1'b0;
    cand_id    = '0;
    cand_lvl   = '0;
    for (int i = 0; i < NumSrc; i++) begin
      if (eligible[i] && (!cand_valid || (src_lvl[i] > cand_lvl))) begin
        cand_valid = 1'b1;
        cand_id    = IdWidth'(i);
        cand_lvl   = src_lvl[i];
      end
    end
  end

  assign win_onehot = {{(NumSrc-1){1'b0}}, 1'b1} << win_id_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_id_q  <= '0;
      win_lvl_q <= '0;
    end else if (load_win) begin
      win_id_q  <= cand_id;
      win_lvl_q <= cand_lvl;
    end
  end

  // Outputs decode only from registered state, so the asynchronous reset
  // clears them without waiting for a clock.
  always_comb begin
    state_d         = state_q;
    load_win        = 1'b0;
    bus.irq_o       = '0;
    bus.irq_level_o = '0;
    bus.clr_o       = '0;
    unique case (state_q)
      IDLE: begin
        if (cand_valid) begin
          load_win = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        bus.irq_o       = win_onehot;
        bus.irq_level_o = win_lvl_q;
        if (bus.irq_ack_i) begin
          state_d = CLEAR;
        end else if (!eligible[win_id_q]) begin
          state_d = IDLE;
        end else if (cand_valid && (cand_lvl > win_lvl_q)) begin
          // Outranked: drop for a cycle and let IDLE pick the new winner.
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (bus.edge_i[win_id_q]) begin
          bus.clr_o = win_onehot;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
endmodule
